// File: rtl/boot_pkg.sv
// Shared definitions for the cpu boot loader: header command encodings,
// header field positions, loader state encoding and header field helpers.
package boot_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD_I  = 2'b00,
    CMD_LOAD_D  = 2'b01,
    CMD_ILLEGAL = 2'b10,
    CMD_RUN     = 2'b11
  } cmd_e;

  localparam int unsigned HDR_CMD_MSB  = 31;
  localparam int unsigned HDR_CMD_LSB  = 30;
  localparam int unsigned HDR_BASE_MSB = 29;
  localparam int unsigned HDR_BASE_LSB = 16;
  localparam int unsigned HDR_CNT_MSB  = 15;
  localparam int unsigned HDR_CNT_LSB  = 0;

  localparam int unsigned HDR_BASE_W = HDR_BASE_MSB - HDR_BASE_LSB + 1;
  localparam int unsigned HDR_CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LI,
    S_LD_LO,
    S_LD_HI,
    S_RUN
  } state_e;

  function automatic cmd_e hdr_cmd(input logic [31:0] word);
    return cmd_e'(word[HDR_CMD_MSB:HDR_CMD_LSB]);
  endfunction

  function automatic logic [HDR_BASE_W-1:0] hdr_base(input logic [31:0] word);
    return word[HDR_BASE_MSB:HDR_BASE_LSB];
  endfunction

  function automatic logic [HDR_CNT_W-1:0] hdr_count(input logic [31:0] word);
    return word[HDR_CNT_MSB:HDR_CNT_LSB];
  endfunction

endpackage

// File: rtl/boot_run_timer.sv
// Cycle-budget timer for a cpu run phase.
// Ports:
//   clk, srst    clock and synchronous active-high reset
//   start        one-cycle request to begin a run with the given budget
//   budget       number of enabled cycles; 0 means run until halt
//   halt         forces the run to end at the next rising edge
//   enable       registered cpu enable, high for the whole run
//   done         registered one-cycle pulse in the cycle after the run ends
//   expire       combinational: the run ends at the coming edge
module boot_run_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [CNT_W-1:0] budget,
  input  logic             halt,
  output logic             enable,
  output logic             done,
  output logic             expire
);

  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // count holds the number of enabled cycles already completed, so comparing
  // the incremented value leaves enable high for exactly `limit` cycles.
  assign count_next = count + CNT_W'(1);
  // Budget hit and halt collapse into one exit term, giving a single done.
  assign expire = enable && (((limit != '0) && (count_next == limit)) || halt);

  always_ff @(posedge clk) begin
    if (srst) begin
      enable <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      limit  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        enable <= 1'b1;
        count  <= '0;
        limit  <= budget;
      end else if (enable) begin
        count <= count_next;
        if (expire) begin
          enable <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cpu_boot_loader.sv
// Stream-driven boot loader for the pipelined cpu. Header words select an
// instruction-memory load, a data-memory load (two beats per doubleword) or a
// budgeted run with the cpu enabled.
// Ports:
//   clk, srst                          clock and synchronous active-high reset
//   in_valid, in_data, in_ready        32-bit command/data stream
//   halt                               forces an active run to stop
//   addr_ext, wen_ext, wdata_ext       imem external write port
//   addr_ext_2, wen_ext_2, wdata_ext_2 dmem external write port
//   cpu_enable                         cpu enable during a run
//   busy                               loader not idle
//   done                               one-cycle pulse at end of a run
//   err                                sticky illegal-command flag
module cpu_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned IMEM_STRIDE = 4,
  parameter int unsigned DMEM_STRIDE = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        halt,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e           state;
  logic [63:0]      addr;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      low_word;

  logic             beat;
  cmd_e             cmd;
  logic [CNT_W-1:0] count;
  logic             run_start;
  logic             run_exit;

  assign in_ready  = (state != S_RUN);
  assign busy      = (state != S_IDLE);
  assign beat      = in_valid && in_ready;
  assign cmd       = hdr_cmd(in_data);
  assign count     = CNT_W'(hdr_count(in_data));
  assign run_start = beat && (state == S_IDLE) && (cmd == CMD_RUN);

  boot_run_timer #(
    .CNT_W(CNT_W)
  ) u_run_timer (
    .clk   (clk),
    .srst  (srst),
    .start (run_start),
    .budget(count),
    .halt  (halt),
    .enable(cpu_enable),
    .done  (done),
    .expire(run_exit)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= S_IDLE;
      addr        <= '0;
      remaining   <= '0;
      low_word    <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      err         <= 1'b0;
    end else begin
      // Write strobes last one cycle; addresses and data hold between writes.
      wen_ext   <= 1'b0;
      wen_ext_2 <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (beat) begin
            unique case (cmd)
              CMD_LOAD_I: begin
                addr      <= 64'(hdr_base(in_data)) * 64'(IMEM_STRIDE);
                remaining <= count;
                if (count != '0) state <= S_LI;
              end
              CMD_LOAD_D: begin
                addr      <= 64'(hdr_base(in_data)) * 64'(DMEM_STRIDE);
                remaining <= count;
                if (count != '0) state <= S_LD_LO;
              end
              CMD_RUN: begin
                state <= S_RUN;
              end
              CMD_ILLEGAL: begin
                err <= 1'b1;
              end
            endcase
          end
        end
        S_LI: begin
          if (beat) begin
            wen_ext   <= 1'b1;
            addr_ext  <= addr;
            wdata_ext <= in_data;
            addr      <= addr + 64'(IMEM_STRIDE);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state <= S_IDLE;
          end
        end
        S_LD_LO: begin
          if (beat) begin
            low_word <= in_data;
            state    <= S_LD_HI;
          end
        end
        S_LD_HI: begin
          if (beat) begin
            wen_ext_2   <= 1'b1;
            addr_ext_2  <= addr;
            wdata_ext_2 <= {in_data, low_word};
            addr        <= addr + 64'(DMEM_STRIDE);
            remaining   <= remaining - CNT_W'(1);
            state       <= (remaining == CNT_W'(1)) ? S_IDLE : S_LD_LO;
          end
        end
        S_RUN: begin
          if (run_exit) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: per-cycle vector tables for the load
// and reset sequences, hand-written sequences for the run phases.
module tb_cpu_boot_loader;

  logic        clk;
  logic        srst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        halt;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic [63:0] wdata_ext_2;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        err;

  // ren_ext / ren_ext_2 of the cpu are tied low at system level.
  logic ren_ext   = 1'b0;
  logic ren_ext_2 = 1'b0;

  cpu_boot_loader dut (
    .clk        (clk),
    .srst       (srst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .halt       (halt),
    .addr_ext   (addr_ext),
    .wen_ext    (wen_ext),
    .wdata_ext  (wdata_ext),
    .addr_ext_2 (addr_ext_2),
    .wen_ext_2  (wen_ext_2),
    .wdata_ext_2(wdata_ext_2),
    .cpu_enable (cpu_enable),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        wen;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        wen2;
    logic [63:0] addr2;
    logic [63:0] wdata2;
    logic        en;
    logic        done;
    logic        err;
  } out_t;

  typedef struct {
    string       name;
    logic        srst;
    logic        valid;
    logic [31:0] data;
    out_t        exp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int overlap = 0;

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] D1 = 32'h0D0D_0001;
  localparam logic [31:0] D2 = 32'h0D0D_0002;
  localparam logic [63:0] W2 = 64'h2222_2222_1111_1111;

  vec_t tab_a[18];
  vec_t tab_b[6];

  function automatic out_t o(logic r, logic b, logic w, logic [63:0] a, logic [31:0] d,
                             logic w2, logic [63:0] a2, logic [63:0] d2,
                             logic e, logic dn, logic er);
    out_t x;
    x = '{ready: r, busy: b, wen: w, addr: a, wdata: d, wen2: w2, addr2: a2, wdata2: d2,
          en: e, done: dn, err: er};
    return x;
  endfunction

  function automatic vec_t mk(string n, logic s, logic v, logic [31:0] d, out_t e);
    vec_t x;
    x.name = n; x.srst = s; x.valid = v; x.data = d; x.exp = e;
    return x;
  endfunction

  function automatic out_t sample();
    return '{ready: in_ready, busy: busy, wen: wen_ext, addr: addr_ext, wdata: wdata_ext,
             wen2: wen_ext_2, addr2: addr_ext_2, wdata2: wdata_ext_2,
             en: cpu_enable, done: done, err: err};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic apply_row(vec_t v);
    out_t got;
    srst     = v.srst;
    in_valid = v.valid;
    in_data  = v.data;
    halt     = 1'b0;
    @(posedge clk);
    #1;
    got = sample();
    total++;
    if (got !== v.exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", v.name, got, v.exp);
    end
  endtask

  // Write strobes must never overlap each other or an enabled cpu.
  always @(negedge clk) begin
    if (srst === 1'b0 && ((wen_ext && wen_ext_2) || ((wen_ext || wen_ext_2) && cpu_enable)))
      overlap++;
  end

  task automatic run_budget_test();
    int en_cycles = 0;
    int done_cycles = 0;
    int ready_bad = 0;
    logic first_en;
    in_valid = 1'b1;
    in_data  = 32'hC000_000A;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    first_en = cpu_enable;
    for (int k = 0; k < 30; k++) begin
      if (cpu_enable) en_cycles++;
      if (done) done_cycles++;
      if (cpu_enable && in_ready) ready_bad++;
      @(posedge clk);
      #1;
    end
    check("run10_first_enable", 64'(first_en), 64'd1);
    check("run10_enable_cycles", 64'(en_cycles), 64'd10);
    check("run10_done_pulses", 64'(done_cycles), 64'd1);
    check("run10_ready_while_run", 64'(ready_bad), 64'd0);
    check("run10_idle_after", 64'(busy), 64'd0);
  endtask

  task automatic run_halt_test();
    int en_cycles = 0;
    in_valid = 1'b1;
    in_data  = 32'hC000_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (cpu_enable && !in_ready) en_cycles++;
      @(posedge clk);
      #1;
    end
    check("halt_enable_before", 64'(en_cycles), 64'd25);
    halt = 1'b1;
    @(posedge clk);
    #1;
    halt = 1'b0;
    check("halt_enable_low", 64'(cpu_enable), 64'd0);
    check("halt_done_pulse", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    check("halt_done_single", 64'(done), 64'd0);
    check("halt_idle_after", 64'(busy), 64'd0);
  endtask

  initial begin
    srst     = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    halt     = 1'b0;

    tab_a[0]  = mk("rst0",    1, 0, 32'h0,         o(1, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0));
    tab_a[1]  = mk("rst1",    1, 0, 32'h0,         o(1, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0));
    tab_a[2]  = mk("li_hdr",  0, 1, 32'h0000_0003, o(1, 1, 0, 0, 0,  0, 0,  0,  0, 0, 0));
    tab_a[3]  = mk("li_a",    0, 1, WA,            o(1, 1, 1, 0, WA, 0, 0,  0,  0, 0, 0));
    tab_a[4]  = mk("li_b",    0, 1, WB,            o(1, 1, 1, 4, WB, 0, 0,  0,  0, 0, 0));
    tab_a[5]  = mk("li_c",    0, 1, WC,            o(1, 0, 1, 8, WC, 0, 0,  0,  0, 0, 0));
    tab_a[6]  = mk("li_end",  0, 0, 32'h0,         o(1, 0, 0, 8, WC, 0, 0,  0,  0, 0, 0));
    tab_a[7]  = mk("ld_hdr",  0, 1, 32'h4002_0001, o(1, 1, 0, 8, WC, 0, 0,  0,  0, 0, 0));
    tab_a[8]  = mk("ld_lo",   0, 1, 32'h1111_1111, o(1, 1, 0, 8, WC, 0, 0,  0,  0, 0, 0));
    tab_a[9]  = mk("ld_hi",   0, 1, 32'h2222_2222, o(1, 0, 0, 8, WC, 1, 16, W2, 0, 0, 0));
    tab_a[10] = mk("ld_end",  0, 0, 32'h0,         o(1, 0, 0, 8, WC, 0, 16, W2, 0, 0, 0));
    tab_a[11] = mk("gap_hdr", 0, 1, 32'h0000_0002, o(1, 1, 0, 8, WC, 0, 16, W2, 0, 0, 0));
    tab_a[12] = mk("gap_w0",  0, 1, D1,            o(1, 1, 1, 0, D1, 0, 16, W2, 0, 0, 0));
    tab_a[13] = mk("gap_1",   0, 0, 32'h0,         o(1, 1, 0, 0, D1, 0, 16, W2, 0, 0, 0));
    tab_a[14] = mk("gap_2",   0, 0, 32'h0,         o(1, 1, 0, 0, D1, 0, 16, W2, 0, 0, 0));
    tab_a[15] = mk("gap_3",   0, 0, 32'h0,         o(1, 1, 0, 0, D1, 0, 16, W2, 0, 0, 0));
    tab_a[16] = mk("gap_w1",  0, 1, D2,            o(1, 0, 1, 4, D2, 0, 16, W2, 0, 0, 0));
    tab_a[17] = mk("gap_end", 0, 0, 32'h0,         o(1, 0, 0, 4, D2, 0, 16, W2, 0, 0, 0));

    tab_b[0] = mk("ill_hdr",   0, 1, 32'h8000_0005, o(1, 0, 0, 4, D2, 0, 16, W2, 0, 0, 1));
    tab_b[1] = mk("ill_idle",  0, 0, 32'h0,         o(1, 0, 0, 4, D2, 0, 16, W2, 0, 0, 1));
    tab_b[2] = mk("mid_hdr",   0, 1, 32'h4000_0001, o(1, 1, 0, 4, D2, 0, 16, W2, 0, 0, 1));
    tab_b[3] = mk("mid_lo",    0, 1, 32'h3333_3333, o(1, 1, 0, 4, D2, 0, 16, W2, 0, 0, 1));
    tab_b[4] = mk("srst_mid",  1, 0, 32'h0,         o(1, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0));
    tab_b[5] = mk("post_srst", 0, 0, 32'h0,         o(1, 0, 0, 0, 0,  0, 0,  0,  0, 0, 0));

    foreach (tab_a[i]) apply_row(tab_a[i]);
    run_budget_test();
    run_halt_test();
    foreach (tab_b[i]) apply_row(tab_b[i]);

    check("no_port_overlap", 64'(overlap), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
